rs232_fifo_periph: RTL

Buffered serial peripheral for the yari peripheral space (FF00_0000 region). It sits between the core's peripheral port and the byte-level `rs232in`/`rs232out` serializers. It replaces unbuffered single-byte handling with parametrised TX and RX FIFOs, an RX overrun flag, a loadable time-stamp counter and a level interrupt. Registers 0–3 keep their existing meanings, so current boot code runs unchanged.

---
 rtl/rs232_fifo_periph.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rs232_fifo_periph.sv
// Buffered RS-232 peripheral: TX/RX FIFOs, overrun/lost flags, loadable TSC and level irq.
// Registers 0-3 keep the legacy unbuffered layout so existing boot code is unaffected.
module rs232_fifo_periph #(
    parameter int unsigned RX_LOG2 = 4,
    parameter int unsigned TX_LOG2 = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [2:0]  per_addr,
    input  logic        per_read,
    input  logic        per_write,
    input  logic [31:0] per_wdata,
    output logic [31:0] per_rdata,
    output logic        per_rvalid,
    input  logic        rs232in_attention,
    input  logic [7:0]  rs232in_data,
    input  logic        rs232out_busy,
    output logic        rs232out_w,
    output logic [7:0]  rs232out_d,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} tx_state_t;

    logic [7:0]       rx_mem [1 << RX_LOG2];
    logic [7:0]       tx_mem [1 << TX_LOG2];
    logic [RX_LOG2:0] rx_wp, rx_rp, rx_count;
    logic [TX_LOG2:0] tx_wp, tx_rp;
    logic             rx_empty, rx_full, tx_empty, tx_full;
    logic             rx_pop, rx_push, tx_pop, tx_push;
    logic             rx_ovr, tx_lost;
    logic [1:0]       irq_en;
    logic [31:0]      tsc, rd_mux;
    tx_state_t        state, state_nx;

    assign rx_count = rx_wp - rx_rp;
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[RX_LOG2] != rx_rp[RX_LOG2]) &&
                      (rx_wp[RX_LOG2-1:0] == rx_rp[RX_LOG2-1:0]);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[TX_LOG2] != tx_rp[TX_LOG2]) &&
                      (tx_wp[TX_LOG2-1:0] == tx_rp[TX_LOG2-1:0]);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds then.
    assign rx_pop  = per_read && (per_addr == 3'd1) && !rx_empty;
    assign rx_push = rs232in_attention && (!rx_full || rx_pop);
    assign tx_pop  = (state == SEND);
    assign tx_push = per_write && (per_addr == 3'd0) && (!tx_full || tx_pop);

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wp[RX_LOG2-1:0]] <= rs232in_data;
        if (tx_push) tx_mem[tx_wp[TX_LOG2-1:0]] <= per_wdata[7:0];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp   <= '0;
            rx_rp   <= '0;
            tx_wp   <= '0;
            tx_rp   <= '0;
            rx_ovr  <= 1'b0;
            tx_lost <= 1'b0;
            irq_en  <= '0;
            tsc     <= '0;
            irq     <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            // Set beats clear when both happen in one cycle.
            rx_ovr  <= (rs232in_attention && !rx_push) ||
                       (rx_ovr && !(per_write && per_addr == 3'd4 && per_wdata[3]));
            tx_lost <= (per_write && per_addr == 3'd0 && !tx_push) ||
                       (tx_lost && !(per_write && per_addr == 3'd4 && per_wdata[4]));
            if (per_write && per_addr == 3'd5) irq_en <= per_wdata[1:0];
            tsc <= (per_write && per_addr == 3'd3) ? per_wdata : tsc + 32'd1;
            irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_empty);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (per_addr)
            3'd0: rd_mux = {31'b0, tx_full};
            3'd1: rd_mux = rx_empty ? 32'd0 : {24'b0, rx_mem[rx_rp[RX_LOG2-1:0]]};
            3'd2: rd_mux = 32'(rx_count);
            3'd3: rd_mux = tsc;
            3'd4: rd_mux = {27'b0, tx_lost, rx_ovr, tx_empty, tx_full, !rx_empty};
            3'd5: rd_mux = {30'b0, irq_en};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            per_rdata  <= '0;
            per_rvalid <= 1'b0;
        end else begin
            per_rvalid <= per_read;
            if (per_read) per_rdata <= rd_mux;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Strobe and data decode straight from state so reset kills an in-flight strobe at once.
    always_comb begin
        state_nx   = state;
        rs232out_w = 1'b0;
        rs232out_d = '0;
        case (state)
            IDLE: if (!tx_empty && !rs232out_busy) state_nx = SEND;
            SEND: begin
                rs232out_w = 1'b1;
                rs232out_d = tx_mem[tx_rp[TX_LOG2-1:0]];
                state_nx   = HOLD;
            end
            HOLD: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule
